// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline-stage register family: the IF/ID payload
// layout, its width, and the stage occupancy encoding.
package pipe_skid_reg_pkg;

  typedef struct packed {
    logic [31:0] pc_link;
    logic [31:0] pc_add;
    logic [31:0] instr;
    logic        p;
  } if_id_payload_t;

  localparam int IF_ID_W = $bits(if_id_payload_t);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } stage_occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake. With SKID_EN = 1 a
// second (skid) entry absorbs the one beat that arrives after downstream
// stalls, so in_ready can be a flop and throughput stays at one per cycle.
// With SKID_EN = 0 the stage is a single register and in_ready is
// combinational from out_ready/hold.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W    = IF_ID_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_occ_e        state;
  stage_occ_e        next_state;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid_in;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;

  // The main entry is valid in every state except EMPTY.
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = main_data;
  assign occupancy = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~hold;

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= OCC_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and load selects; flush overrides any handshake this cycle.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      next_state = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            next_state   = OCC_ONE;
            load_main_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && SKID_EN) begin
            next_state   = OCC_TWO;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            next_state = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            next_state     = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          next_state = OCC_EMPTY;
        end
      endcase
    end
  end

  // Main payload: cleared on reset/flush, loaded from input or promoted from skid.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      main_data <= RESET_VAL;
    end else if (load_main_in) begin
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_q;

      // Skid payload captures the beat accepted while downstream is stalled.
      always_ff @(posedge clk) begin
        if (!rstn || flush) begin
          skid_data <= RESET_VAL;
        end else if (load_skid_in) begin
          skid_data <= in_data;
        end
      end

      // Registered ready: low exactly when the next state holds two entries.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (next_state != OCC_TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_data = RESET_VAL;
      assign in_ready  = ~out_valid | (out_ready & ~hold);
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: reset, streaming, back-pressure, flush and hold
// on the skid build, plus the combinational-ready behaviour of the
// single-register build. A queue scoreboard tracks accepted beats.
module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  localparam int W = IF_ID_W;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         hold;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic         in_ready0;
  logic         out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   occupancy0;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 1'b1;
  logic [W-1:0] sbq[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(W), .RESET_VAL('0), .SKID_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.DATA_W(W), .RESET_VAL('0), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         h;
    logic         f;
    logic         ov;
    logic         cd;
    logic [W-1:0] od;
    logic [1:0]   occ;
    logic         ir;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic ordy, logic h, logic f,
                              logic ov, logic cd, logic [W-1:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.h = h; v.f = f;
    v.ov = ov; v.cd = cd; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic h, input logic f);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    hold      = h;
    flush     = f;
  endtask

  // Scoreboard: inputs are stable at negedge and are what the next posedge sees.
  always @(negedge clk) begin
    if (sb_on) begin
      if (!rstn || flush) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready && !hold) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got %0h expected no output", out_data);
          end else begin
            chk("sb_order", out_data, sbq.pop_front());
          end
        end
        if (in_valid && in_ready) sbq.push_back(in_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 'hA,  1, 0, 0, 0, 0, 0,     0, 1);
    tbl[1]  = mk(1, 'hB,  0, 0, 0, 1, 1, 'hA,  1, 1);
    tbl[2]  = mk(0, 0,    0, 0, 0, 1, 1, 'hA,  2, 0);
    tbl[3]  = mk(0, 0,    1, 0, 0, 1, 1, 'hA,  2, 0);
    tbl[4]  = mk(0, 0,    1, 0, 0, 1, 1, 'hB,  1, 1);
    tbl[5]  = mk(0, 0,    1, 0, 0, 0, 0, 0,     0, 1);
    tbl[6]  = mk(1, 'h21, 0, 0, 0, 0, 0, 0,     0, 1);
    tbl[7]  = mk(1, 'h22, 0, 0, 0, 1, 1, 'h21, 1, 1);
    tbl[8]  = mk(1, 'hC,  0, 0, 1, 1, 1, 'h21, 2, 0);
    tbl[9]  = mk(0, 0,    1, 0, 0, 0, 1, 0,     0, 1);
    tbl[10] = mk(0, 0,    1, 0, 0, 0, 1, 0,     0, 1);
    tbl[11] = mk(1, 'h31, 1, 0, 0, 0, 1, 0,     0, 1);
    tbl[12] = mk(1, 'h32, 1, 0, 1, 1, 1, 'h31, 1, 1);
    tbl[13] = mk(0, 0,    1, 0, 0, 0, 1, 0,     0, 1);
    tbl[14] = mk(1, 'hD,  1, 1, 0, 0, 1, 0,     0, 1);
    tbl[15] = mk(1, 'hE,  1, 1, 0, 1, 1, 'hD,  1, 1);
    tbl[16] = mk(1, 'hF,  1, 1, 0, 1, 1, 'hD,  2, 0);
    tbl[17] = mk(1, 'hF,  1, 0, 0, 1, 1, 'hD,  2, 0);
    tbl[18] = mk(1, 'hF,  1, 0, 0, 1, 1, 'hE,  1, 1);
    tbl[19] = mk(0, 0,    1, 0, 0, 1, 1, 'hF,  1, 1);
    tbl[20] = mk(0, 0,    1, 0, 0, 0, 0, 0,     0, 1);

    // Reset with a beat presented throughout.
    rstn = 1'b0; flush = 1'b0; hold = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 97'h1_2345;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out_data",  out_data,      0);
    chk("rst_occupancy", W'(occupancy), 0);
    chk("rst_in_ready",  W'(in_ready),  1);
    @(posedge clk);
    #1;
    rstn = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", W'(out_valid), 0);
    chk("post_rst_out_data",  out_data,      0);
    chk("post_rst_occupancy", W'(occupancy), 0);
    chk("post_rst_in_ready",  W'(in_ready),  1);

    // Streaming 0x10..0x1F with downstream always ready.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'(16 + i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 0) begin
        chk("stream_first_ov", W'(out_valid), 0);
      end else begin
        chk($sformatf("stream_ov_%0d", i),  W'(out_valid), 1);
        chk($sformatf("stream_od_%0d", i),  out_data,      W'(15 + i));
        chk($sformatf("stream_occ_%0d", i), W'(occupancy), 1);
        chk($sformatf("stream_ir_%0d", i),  W'(in_ready),  1);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_last_ov", W'(out_valid), 1);
    chk("stream_last_od", out_data,      W'(31));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_end_ov", W'(out_valid), 0);

    // Back-pressure, flush and hold vectors.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].h, tbl[i].f);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(tbl[i].ov));
      chk($sformatf("vec%0d_occupancy", i), W'(occupancy), W'(tbl[i].occ));
      chk($sformatf("vec%0d_in_ready", i),  W'(in_ready),  W'(tbl[i].ir));
      if (tbl[i].cd) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
    end
    chk("sb_drained", W'(sbq.size()), 0);

    // Single-register build: ready follows out_ready/hold within the cycle.
    sb_on = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; hold = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1; in_valid = 1'b1; in_data = 'hA; out_ready = 1'b1;
    @(negedge clk);
    chk("ns_empty_ov",  W'(out_valid0),  0);
    chk("ns_empty_occ", W'(occupancy0),  0);
    chk("ns_empty_ir",  W'(in_ready0),   1);
    @(posedge clk);
    #1;
    in_data = 'hB; out_ready = 1'b0;
    @(negedge clk);
    chk("ns_stall_ir",  W'(in_ready0),  0);
    chk("ns_stall_ov",  W'(out_valid0), 1);
    chk("ns_stall_od",  out_data0,      'hA);
    chk("ns_stall_occ", W'(occupancy0), 1);
    out_ready = 1'b1;
    #1;
    chk("ns_comb_ir", W'(in_ready0), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ns_next_od",  out_data0,      'hB);
    chk("ns_next_occ", W'(occupancy0), 1);
    hold = 1'b1;
    #1;
    chk("ns_hold_ir", W'(in_ready0), 0);
    hold = 1'b0;
    #1;
    chk("ns_unhold_ir", W'(in_ready0), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ns_drain_ov",  W'(out_valid0), 0);
    chk("ns_drain_occ", W'(occupancy0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register, the successor to the fixed IF/ID register. Carries an arbitrary packed payload between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush for bubble insertion, and a hold input for external stalls. Instantiated between IF/ID, ID/EX and the later stages with the payload width set per stage.

Parameters:
DATA_W, 97, payload width in bits; default = PC_link 32 + PC_add 32 + instr 32 + P 1.
RESET_VAL, '0 (DATA_W bits), value loaded into all data storage on reset or flush.
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  in  1  clock; all logic on posedge.
rstn  in  1  synchronous reset, active-low.
flush  in  1  synchronous clear of stage contents; inserts a bubble.
hold  in  1  external stall; blocks output transfer.
in_valid  in  1  upstream data valid.
in_ready  out  1  stage can accept in_data this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  payload to downstream; driven from the main register.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset and clock: reset rstn, synchronous, active-low; clock clk.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & !hold.
- Reset values:
  - out_valid = 0, occupancy = 0, out_data = RESET_VAL, skid data = RESET_VAL.
  - in_ready = 1 when SKID_EN = 1.
  - Any in_fire during the reset cycle is discarded.
- Storage:
  - main {valid, data} drives out_valid/out_data.
  - skid {valid, data} exists only when SKID_EN = 1.
- State encoding:
  - EMPTY = neither valid.
  - ONE = main valid only.
  - TWO = main and skid valid.
- Transitions, SKID_EN = 1:
  - EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main <= in_data.
  - ONE: in_fire & !out_fire -> TWO, skid <= in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither -> stay.
  - TWO: in_fire is impossible; out_fire -> ONE, main <= skid; otherwise stay.
  - in_ready is a flop equal to !skid_valid of the next state, so it is 0 exactly in TWO.
- SKID_EN = 0:
  - TWO is unreachable.
  - in_ready = !main_valid | (out_ready & !hold), combinational.
  - Otherwise the EMPTY/ONE transitions above apply.
- Timing:
  - Latency in_fire -> out_valid is 1 cycle.
  - Sustained throughput is 1 transfer/cycle when out_ready = 1 and hold = 0.
- Stability: while out_valid & !out_fire, out_data and out_valid are held constant. Registers not loaded in a cycle keep their value.
- flush:
  - Next state is EMPTY; main and skid data <= RESET_VAL; occupancy = 0.
  - in_ready = 1 next cycle.
  - An in_fire or out_fire in the flush cycle is ignored for storage purposes. Downstream may still have sampled out_data that cycle; the consumer owns that.
- Priority: rstn > flush > normal operation.
- hold:
  - Suppresses out_fire only; in_fire is still allowed while space exists.
  - Held with continuous input, the stage fills to TWO and then deasserts in_ready.
- No combinational path from in_valid or in_data to out_valid or out_data.
- With SKID_EN = 1 there is also no combinational path from out_ready to in_ready.
- occupancy equals the state encoding: EMPTY = 0, ONE = 1, TWO = 2.

Decomposition:
- my_pkg additions:
  - if_id_payload_t packed struct {pc_link[31:0], pc_add[31:0], instr[31:0], p}.
  - Constant IF_ID_W = $bits(if_id_payload_t).
  - stage_occ_e enum {OCC_EMPTY = 0, OCC_ONE = 1, OCC_TWO = 2}.
- Single module; no sub-module is warranted. Skid and main storage are inline generate branches keyed on SKID_EN.

Test Plan:
- Reset: hold rstn = 0 for 2 cycles with in_valid = 1 and in_data = 97'h1_2345 -> out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1; first post-reset cycle shows nothing latched.
- Streaming: out_ready = 1, push 0x10..0x1F on consecutive cycles -> each appears on out_data exactly 1 cycle later; out_valid stays high for 16 cycles; occupancy = 1.
- Back-pressure: ONE holding A; drop out_ready and push B -> occupancy = 2, in_ready = 0 next cycle, out_data = A. Raise out_ready -> A then B drain in order, no loss or duplication.
- Flush in TWO with simultaneous in_valid = 1 (data C) -> next cycle out_valid = 0, occupancy = 0, out_data = RESET_VAL, in_ready = 1; C never appears.
- hold: hold = 1, out_ready = 1, push D, E, F -> D held on out_data with occupancy = 2 and in_ready = 0 after E; F not accepted. Release hold -> D, E, then F emerge.
- SKID_EN = 0 build: same back-pressure stimulus -> in_ready drops combinationally in the cycle out_ready = 0 with main valid; occupancy never exceeds 1.
